// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: permutation tables, shift schedule and FSM states.
// Tables use FIPS 46-3 1-based bit numbering, where bit 1 is the MSB of the vector.
package des_pkg;

   localparam int KEY_W    = 64;
   localparam int HALF_W   = 28;
   localparam int CD_W     = 56;
   localparam int SUBKEY_W = 48;
   localparam int ROUNDS   = 16;

   localparam int PC1_TBL [CD_W] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TBL [SUBKEY_W] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   // Bit r-1 set means round r uses a single-bit rotate (rounds 1, 2, 9, 16).
   localparam logic [ROUNDS-1:0] SHIFT1_MASK = 16'h8103;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EMIT   = 2'd1,
      FINISH = 2'd2
   } ks_state_e;

   // Rotate amount for a 0-based round index: 1'b1 means a 2-bit rotate.
   function automatic logic double_shift(input logic [3:0] round0);
      return ~SHIFT1_MASK[round0];
   endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression: 56-bit {C,D} to a 48-bit DES round subkey.
// Purely combinational so the round datapath can reuse it.
module des_pc2
   import des_pkg::*;
(
   input  logic [CD_W-1:0]     i_cd,
   output logic [SUBKEY_W-1:0] o_subkey
);

   always_comb begin
      o_subkey = '0;
      for (int j = 0; j < SUBKEY_W; j++) begin
         o_subkey[SUBKEY_W-1-j] = i_cd[CD_W-PC2_TBL[j]];
      end
   end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: streams K1..K16 (or K16..K1) over valid/ready,
// one subkey per accepted handshake, then pulses done for one cycle.
module des_key_schedule
   import des_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                decrypt,
   input  logic [KEY_W-1:0]    key,
   input  logic                subkey_ready,
   output logic                subkey_valid,
   output logic [SUBKEY_W-1:0] subkey,
   output logic [3:0]          round_idx,
   output logic                busy,
   output logic                done
);

   function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
      logic [CD_W-1:0] r;
      r = '0;
      for (int j = 0; j < CD_W; j++) begin
         r[CD_W-1-j] = k[KEY_W-PC1_TBL[j]];
      end
      return r;
   endfunction

   function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input logic two);
      return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
   endfunction

   function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input logic two);
      return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
   endfunction

   ks_state_e           r_state;
   logic [HALF_W-1:0]   r_c;
   logic [HALF_W-1:0]   r_d;
   logic [3:0]          r_cnt;
   logic                r_dec;
   logic                r_valid;
   logic                r_busy;
   logic                r_done;
   logic [3:0]          r_idx;

   logic [CD_W-1:0]     w_pc1;
   logic                w_hs;
   logic                w_enc_two;
   logic                w_dec_two;
   logic [HALF_W-1:0]   w_c_next;
   logic [HALF_W-1:0]   w_d_next;

   assign w_pc1 = pc1(key);
   assign w_hs  = r_valid & subkey_ready;

   // Encrypt steps K(cnt+1) -> K(cnt+2); decrypt steps K(16-cnt) -> K(15-cnt).
   assign w_enc_two = double_shift(r_cnt + 4'd1);
   assign w_dec_two = double_shift(4'd15 - r_cnt);

   always_comb begin
      w_c_next = r_c;
      w_d_next = r_d;
      if (r_dec) begin
         w_c_next = rotr28(r_c, w_dec_two);
         w_d_next = rotr28(r_d, w_dec_two);
      end else begin
         w_c_next = rotl28(r_c, w_enc_two);
         w_d_next = rotl28(r_d, w_enc_two);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_c     <= '0;
         r_d     <= '0;
         r_cnt   <= '0;
         r_dec   <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  // PC-1 output is already {C16,D16} since the total rotation is 28.
                  if (decrypt) begin
                     r_c   <= w_pc1[CD_W-1:HALF_W];
                     r_d   <= w_pc1[HALF_W-1:0];
                     r_idx <= 4'd15;
                  end else begin
                     r_c   <= rotl28(w_pc1[CD_W-1:HALF_W], 1'b0);
                     r_d   <= rotl28(w_pc1[HALF_W-1:0], 1'b0);
                     r_idx <= 4'd0;
                  end
                  r_cnt   <= '0;
                  r_dec   <= decrypt;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= EMIT;
               end
            end
            EMIT: begin
               if (w_hs) begin
                  if (r_cnt == 4'd15) begin
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= FINISH;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                     r_c   <= w_c_next;
                     r_d   <= w_d_next;
                     r_idx <= r_dec ? (4'd14 - r_cnt) : (r_cnt + 4'd1);
                  end
               end
            end
            FINISH: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   des_pc2 u_pc2 (
      .i_cd     ({r_c, r_d}),
      .o_subkey (subkey)
   );

   assign subkey_valid = r_valid;
   assign round_idx    = r_idx;
   assign busy         = r_busy;
   assign done         = r_done;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: known-answer table, backpressure,
// ignored restart, async reset mid-schedule, and random keys against a reference model.
module tb_des_key_schedule;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        decrypt;
   logic [63:0] key;
   logic        subkey_ready;
   logic        subkey_valid;
   logic [47:0] subkey;
   logic [3:0]  round_idx;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_errs   = 0;

   des_key_schedule dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .decrypt      (decrypt),
      .key          (key),
      .subkey_ready (subkey_ready),
      .subkey_valid (subkey_valid),
      .subkey       (subkey),
      .round_idx    (round_idx),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: FIPS tables, cumulative rotation counts from C0/D0.
   int tb_pc1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                       19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                       14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   int tb_pc2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                       41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
   int tb_shift [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   logic [47:0] exp_ks [16];
   logic [47:0] got_ks [16];
   logic [3:0]  got_idx [16];
   logic [47:0] enc_seq [16];

   function automatic logic [27:0] mrotl(input logic [27:0] x, input int n);
      logic [55:0] xx;
      xx = {x, x};
      return xx[55-n -: 28];
   endfunction

   task automatic compute_model(input logic [63:0] k);
      logic [55:0] cd;
      logic [55:0] cdr;
      logic [27:0] c0, d0;
      int tot;
      for (int j = 0; j < 56; j++) cd[55-j] = k[64-tb_pc1[j]];
      c0 = cd[55:28];
      d0 = cd[27:0];
      tot = 0;
      for (int r = 0; r < 16; r++) begin
         tot += tb_shift[r];
         cdr = {mrotl(c0, tot), mrotl(d0, tot)};
         for (int m = 0; m < 48; m++) exp_ks[r][47-m] = cdr[56-tb_pc2[m]];
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Runs one schedule; returns early (no completion checks) after abort_n handshakes.
   task automatic run_ks(input logic [63:0] k, input logic d, input bit rnd,
                         input bit inj, input int abort_n);
      int n, cyc;
      bit r, prev_stall;
      logic [47:0] prev_sk;
      logic [3:0]  prev_idx;
      compute_model(k);
      @(negedge clk);
      start = 1'b1; key = k; decrypt = d; subkey_ready = 1'b1;
      @(negedge clk);
      start = 1'b0; key = {$urandom, $urandom}; decrypt = ~d;
      n = 0; cyc = 0; prev_stall = 0; prev_sk = '0; prev_idx = '0;
      while (n < 16 && cyc < 400) begin
         chk("valid_held", {63'd0, subkey_valid}, 64'd1);
         if (prev_stall) begin
            chk("stall_stable", {12'd0, subkey, round_idx}, {12'd0, prev_sk, prev_idx});
         end
         if (abort_n != 0 && n == abort_n) break;
         if (inj && n == 3) begin
            start = 1'b1; key = ~k; decrypt = ~d;
         end else begin
            start = 1'b0;
         end
         r = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         subkey_ready = r;
         if (r) begin
            got_ks[n]  = subkey;
            got_idx[n] = round_idx;
            chk($sformatf("subkey_hs%0d", n), {12'd0, subkey, round_idx},
                {12'd0, (d ? exp_ks[15-n] : exp_ks[n]), (d ? 4'(15-n) : 4'(n))});
            n++;
         end
         prev_stall = !r;
         prev_sk    = subkey;
         prev_idx   = round_idx;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      subkey_ready = 1'b0;
      if (abort_n != 0 && n == abort_n) return;
      if (n < 16) begin
         chk("handshake_timeout", 64'(n), 64'd16);
         return;
      end
      if (!rnd) chk("zero_stall_cycles", 64'(cyc), 64'd16);
      chk("done_pulse", {61'd0, done, subkey_valid, busy}, {61'd0, 3'b101});
      @(negedge clk);
      chk("back_idle", {61'd0, done, subkey_valid, busy}, 64'd0);
   endtask

   typedef struct {
      logic [63:0] key;
      logic        dec;
      logic [47:0] first;
      logic [3:0]  first_idx;
      logic [47:0] last;
   } vec_t;

   vec_t vecs [4];

   initial begin
      vecs[0] = '{64'h133457799BBCDFF1, 1'b0, 48'h1B02EFFC7072, 4'd0,  48'hCB3D8B0E17F5};
      vecs[1] = '{64'h133457799BBCDFF1, 1'b1, 48'hCB3D8B0E17F5, 4'd15, 48'h1B02EFFC7072};
      vecs[2] = '{64'hFEFEFEFEFEFEFEFE, 1'b0, 48'hFFFFFFFFFFFF, 4'd0,  48'hFFFFFFFFFFFF};
      vecs[3] = '{64'h0101010101010101, 1'b1, 48'h000000000000, 4'd15, 48'h000000000000};

      rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; key = '0; subkey_ready = 1'b0;
      #12;
      chk("reset_outputs", {5'd0, subkey_valid, busy, done, round_idx, subkey}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {61'd0, subkey_valid, busy, done}, 64'd0);

      for (int v = 0; v < 4; v++) begin
         run_ks(vecs[v].key, vecs[v].dec, 1'b0, 1'b0, 0);
         chk($sformatf("vec%0d_first", v), {12'd0, got_ks[0], got_idx[0]},
             {12'd0, vecs[v].first, vecs[v].first_idx});
         chk($sformatf("vec%0d_last", v), {16'd0, got_ks[15]}, {16'd0, vecs[v].last});
         if (v == 0) for (int i = 0; i < 16; i++) enc_seq[i] = got_ks[i];
         if (v == 1) begin
            for (int i = 0; i < 16; i++)
               chk($sformatf("dec_reverse%0d", i), {16'd0, got_ks[i]}, {16'd0, enc_seq[15-i]});
         end
         if (v >= 2) begin
            for (int i = 0; i < 16; i++)
               chk($sformatf("vec%0d_const%0d", v, i), {16'd0, got_ks[i]}, {16'd0, vecs[v].first});
         end
      end

      // Backpressure on the standard key.
      run_ks(64'h133457799BBCDFF1, 1'b0, 1'b1, 1'b0, 0);
      for (int i = 0; i < 16; i++)
         chk($sformatf("bp_seq%0d", i), {16'd0, got_ks[i]}, {16'd0, enc_seq[i]});

      // Restart attempt during EMIT must be ignored.
      run_ks(64'h133457799BBCDFF1, 1'b0, 1'b1, 1'b1, 0);
      chk("inj_last", {16'd0, got_ks[15]}, 64'h0000CB3D8B0E17F5);

      // Async reset after the 5th handshake.
      run_ks(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0, 5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrun_reset", {5'd0, subkey_valid, busy, done, round_idx, subkey}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_ks(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0, 0);
      chk("post_reset_k1", {12'd0, got_ks[0], got_idx[0]}, {12'd0, 48'h1B02EFFC7072, 4'd0});

      // Random keys, direction and backpressure.
      for (int t = 0; t < 6; t++) begin
         run_ks({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
